// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU-subsystem offload interface.
// Holds the issue payload, the scoreboard entry and the issuer FSM states.
package fpu_ss_pkg;

    localparam int XifIdW = 4;

    typedef struct packed {
        logic [2:0][31:0]  rs;
        logic [31:0]       instr_data;
        logic [XifIdW-1:0] id;
        logic [1:0]        mode;
    } offloaded_data_t;

    typedef struct packed {
        logic              valid;
        logic [XifIdW-1:0] id;
        logic [4:0]        rd;
    } xif_sb_entry_t;

    typedef enum logic [0:0] {
        XIF_IDLE  = 1'b0,
        XIF_ISSUE = 1'b1
    } xif_state_e;

endpackage

// File: rtl/xif_offload_issuer_if.sv
// Issue and result channels between the core-side issuer and the coprocessor.
// master = issuer (core side), slave = coprocessor.
interface xif_offload_issuer_if;
    import fpu_ss_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    offloaded_data_t   issue_data;
    logic              issue_accept;
    logic              issue_writeback;

    logic              result_valid;
    logic              result_ready;
    logic [XifIdW-1:0] result_id;
    logic [4:0]        result_rd;
    logic              result_we;
    logic [31:0]       result_data;

    modport master (
        output issue_valid, issue_data, result_ready,
        input  issue_ready, issue_accept, issue_writeback,
        input  result_valid, result_id, result_rd,
        input  result_we, result_data
    );

    modport slave (
        input  issue_valid, issue_data, result_ready,
        output issue_ready, issue_accept, issue_writeback,
        output result_valid, result_id, result_rd,
        output result_we, result_data
    );

endinterface

// File: rtl/xif_offload_sb.sv
// Scoreboard of outstanding writeback instructions: alloc, free-by-id,
// register hazard, id clash and full detection from the registered table.
module xif_offload_sb
    import fpu_ss_pkg::*;
#(
    parameter int NUM_OUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_i,
    input  logic [XifIdW-1:0] alloc_id_i,
    input  logic [4:0]        alloc_rd_i,
    input  logic              free_i,
    input  logic [XifIdW-1:0] free_id_i,
    output logic              free_hit_o,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rs3_i,
    input  logic [4:0]        rd_i,
    output logic              hazard_o,
    input  logic [XifIdW-1:0] query_id_i,
    output logic              clash_o,
    output logic              full_o,
    output logic              any_valid_o
);

    xif_sb_entry_t      ent_q [NUM_OUT];
    logic [NUM_OUT-1:0] alloc_sel;
    logic [NUM_OUT-1:0] free_sel;

    always_comb begin
        hazard_o    = 1'b0;
        clash_o     = 1'b0;
        full_o      = 1'b1;
        any_valid_o = 1'b0;
        free_hit_o  = 1'b0;
        alloc_sel   = '0;
        free_sel    = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (ent_q[i].valid) begin
                any_valid_o = 1'b1;
                // x0 is never a hazard source
                if (rs1_i != 5'd0 && rs1_i == ent_q[i].rd) hazard_o = 1'b1;
                if (rs2_i != 5'd0 && rs2_i == ent_q[i].rd) hazard_o = 1'b1;
                if (rs3_i != 5'd0 && rs3_i == ent_q[i].rd) hazard_o = 1'b1;
                if (rd_i  != 5'd0 && rd_i  == ent_q[i].rd) hazard_o = 1'b1;
                if (ent_q[i].id == query_id_i) clash_o = 1'b1;
                if (!free_hit_o && ent_q[i].id == free_id_i) begin
                    free_sel[i] = 1'b1;
                    free_hit_o  = 1'b1;
                end
            end else begin
                full_o = 1'b0;
                if (alloc_sel == '0) alloc_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_OUT; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (free_i && free_sel[i]) ent_q[i].valid <= 1'b0;
                if (alloc_i && alloc_sel[i]) begin
                    ent_q[i] <= '{valid: 1'b1, id: alloc_id_i, rd: alloc_rd_i};
                end
            end
        end
    end

endmodule

// File: rtl/xif_offload_issuer.sv
// Core-side offload issuer: issue FSM, writeback scoreboard and result routing.
// XIF_OFFLOAD_RSP_REG_EN registers the result channel before the rf write port.
module xif_offload_issuer
    import fpu_ss_pkg::*;
#(
    parameter int NUM_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instr_data_i,
    input  logic [2:0][31:0]      instr_rs_i,
    input  logic [1:0]            instr_mode_i,
    output logic                  instr_accept_o,
    output logic                  instr_reject_o,
    xif_offload_issuer_if.master  xif,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [31:0]           rf_wdata_o,
    output logic                  busy_o,
    output logic                  err_o
);

    xif_state_e        state_q, state_d;
    offloaded_data_t   issue_q;
    logic [XifIdW-1:0] next_id_q;
    logic              err_q;
    logic              capture, alloc, id_inc;
    logic              full, hazard, clash, any_valid, free_hit;

    logic              rsp_valid, rsp_we;
    logic [XifIdW-1:0] rsp_id;
    logic [4:0]        rsp_rd;
    logic [31:0]       rsp_data;

    xif_offload_sb #(.NUM_OUT(NUM_OUT)) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (alloc),
        .alloc_id_i  (issue_q.id),
        .alloc_rd_i  (issue_q.instr_data[11:7]),
        .free_i      (rsp_valid),
        .free_id_i   (rsp_id),
        .free_hit_o  (free_hit),
        .rs1_i       (instr_data_i[19:15]),
        .rs2_i       (instr_data_i[24:20]),
        .rs3_i       (instr_data_i[31:27]),
        .rd_i        (instr_data_i[11:7]),
        .hazard_o    (hazard),
        .query_id_i  (next_id_q),
        .clash_o     (clash),
        .full_o      (full),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d         = state_q;
        instr_ready_o   = 1'b0;
        xif.issue_valid = 1'b0;
        instr_accept_o  = 1'b0;
        instr_reject_o  = 1'b0;
        capture         = 1'b0;
        alloc           = 1'b0;
        id_inc          = 1'b0;
        unique case (state_q)
            XIF_IDLE: begin
                instr_ready_o = !full && !hazard && !clash;
                if (instr_valid_i && instr_ready_o) begin
                    capture = 1'b1;
                    state_d = XIF_ISSUE;
                end
            end
            XIF_ISSUE: begin
                xif.issue_valid = 1'b1;
                if (xif.issue_ready) begin
                    state_d = XIF_IDLE;
                    if (xif.issue_accept) begin
                        instr_accept_o = 1'b1;
                        id_inc         = 1'b1;
                        alloc          = xif.issue_writeback;
                    end else begin
                        instr_reject_o = 1'b1;
                    end
                end
            end
            default: state_d = XIF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= XIF_IDLE;
            issue_q   <= '0;
            next_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                issue_q <= '{rs: instr_rs_i, instr_data: instr_data_i,
                             id: next_id_q, mode: instr_mode_i};
            end
            if (id_inc) next_id_q <= next_id_q + 1'b1;
            // unmatched result id is sticky; the rf write still happens
            if (rsp_valid && !free_hit) err_q <= 1'b1;
        end
    end

`ifdef XIF_OFFLOAD_RSP_REG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_id    <= '0;
            rsp_rd    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= xif.result_valid;
            rsp_we    <= xif.result_we;
            rsp_id    <= xif.result_id;
            rsp_rd    <= xif.result_rd;
            rsp_data  <= xif.result_data;
        end
    end
`else
    assign rsp_valid = xif.result_valid;
    assign rsp_we    = xif.result_we;
    assign rsp_id    = xif.result_id;
    assign rsp_rd    = xif.result_rd;
    assign rsp_data  = xif.result_data;
`endif

    assign xif.result_ready = 1'b1;
    assign xif.issue_data   = issue_q;
    assign rf_we_o          = rsp_valid && rsp_we && (rsp_rd != 5'd0);
    assign rf_waddr_o       = rsp_rd;
    assign rf_wdata_o       = rsp_data;
    assign busy_o           = any_valid || (state_q != XIF_IDLE);
    assign err_o            = err_q;

endmodule

// File: tb/tb_xif_offload_issuer.sv
// Directed self-checking bench for xif_offload_issuer (default build, NUM_OUT=4).
module tb_xif_offload_issuer;
    import fpu_ss_pkg::*;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             instr_valid_i;
    logic             instr_ready_o;
    logic [31:0]      instr_data_i;
    logic [2:0][31:0] instr_rs_i;
    logic [1:0]       instr_mode_i;
    logic             instr_accept_o;
    logic             instr_reject_o;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic             busy_o;
    logic             err_o;

    int n_vec = 0;
    int n_err = 0;

    xif_offload_issuer_if xif();

    xif_offload_issuer #(.NUM_OUT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_data_i   (instr_data_i),
        .instr_rs_i     (instr_rs_i),
        .instr_mode_i   (instr_mode_i),
        .instr_accept_o (instr_accept_o),
        .instr_reject_o (instr_reject_o),
        .xif            (xif),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h13};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_result(input logic v, input logic [3:0] id,
                              input logic [4:0] rd, input logic we,
                              input logic [31:0] d);
        xif.result_valid = v;
        xif.result_id    = id;
        xif.result_rd    = rd;
        xif.result_we    = we;
        xif.result_data  = d;
    endtask

    task automatic issue_one(input logic [31:0] instr, input logic wb,
                             input logic acc, output logic [3:0] id,
                             output logic ap, output logic rp, output bit ok);
        ok = 1'b0;
        id = '0;
        ap = 1'b0;
        rp = 1'b0;
        instr_data_i  = instr;
        instr_valid_i = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (instr_ready_o) begin
                ok = 1'b1;
                break;
            end
            cyc();
            #1;
        end
        if (!ok) begin
            instr_valid_i = 1'b0;
            return;
        end
        cyc();
        instr_valid_i       = 1'b0;
        id                  = xif.issue_data.id;
        xif.issue_ready     = 1'b1;
        xif.issue_accept    = acc;
        xif.issue_writeback = wb;
        #1;
        ap = instr_accept_o;
        rp = instr_reject_o;
        cyc();
        xif.issue_ready     = 1'b0;
        xif.issue_accept    = 1'b0;
        xif.issue_writeback = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        instr_valid_i = 1'b0;
        instr_data_i  = '0;
        instr_rs_i    = '0;
        instr_mode_i  = '0;
        xif.issue_ready     = 1'b0;
        xif.issue_accept    = 1'b0;
        xif.issue_writeback = 1'b0;
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        #12;
        n_vec++;
        if ({xif.issue_valid, instr_accept_o, instr_reject_o, rf_we_o,
             busy_o, err_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {xif.issue_valid, instr_accept_o, instr_reject_o,
                      rf_we_o, busy_o, err_o});
        end
        n_vec++;
        if (xif.issue_data !== '0) begin
            n_err++;
            $display("FAIL reset_issue_data: got %h want 0", xif.issue_data);
        end
        rst_ni = 1'b1;
        cyc();
        n_vec++;
        if (instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", instr_ready_o);
        end
    endtask

    task automatic test_issue_wb();
        offloaded_data_t exp_d;
        instr_rs_i    = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        instr_mode_i  = 2'b11;
        instr_data_i  = mk(5'd5, 5'd1, 5'd2);
        instr_valid_i = 1'b1;
        exp_d = '{rs: instr_rs_i, instr_data: mk(5'd5, 5'd1, 5'd2),
                  id: 4'd0, mode: 2'b11};
        cyc();
        instr_valid_i = 1'b0;
        n_vec++;
        if (xif.issue_valid !== 1'b1 || xif.issue_data !== exp_d) begin
            n_err++;
            $display("FAIL issue_payload: got v=%b %h want v=1 %h",
                     xif.issue_valid, xif.issue_data, exp_d);
        end
        xif.issue_ready     = 1'b1;
        xif.issue_accept    = 1'b1;
        xif.issue_writeback = 1'b1;
        #1;
        n_vec++;
        if ({instr_accept_o, instr_reject_o} !== 2'b10) begin
            n_err++;
            $display("FAIL accept_pulse: got %b want 10",
                     {instr_accept_o, instr_reject_o});
        end
        cyc();
        xif.issue_ready     = 1'b0;
        xif.issue_accept    = 1'b0;
        xif.issue_writeback = 1'b0;
        n_vec++;
        if ({busy_o, xif.issue_valid, instr_accept_o} !== 3'b100) begin
            n_err++;
            $display("FAIL after_accept: got busy/valid/acc=%b want 100",
                     {busy_o, xif.issue_valid, instr_accept_o});
        end
    endtask

    task automatic test_hazard();
        logic [3:0] id;
        logic ap, rp;
        bit ok;
        instr_data_i  = mk(5'd6, 5'd5, 5'd0);
        instr_valid_i = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (instr_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL hazard_stall[%0d]: got %b want 0", c, instr_ready_o);
            end
            cyc();
        end
        set_result(1'b1, 4'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
        #1;
        n_vec++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, instr_ready_o}
            !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL result_write: got we=%b a=%0d d=%h rdy=%b want 1 5 deadbeef 0",
                     rf_we_o, rf_waddr_o, rf_wdata_o, instr_ready_o);
        end
        cyc();
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_release: got %b want 1", instr_ready_o);
        end
        issue_one(mk(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, id, ap, rp, ok);
        n_vec++;
        if (!ok || id !== 4'd1 || ap !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL second_issue: got ok=%b id=%0d acc=%b busy=%b want 1 1 1 0",
                     ok, id, ap, busy_o);
        end
    endtask

    task automatic test_stall_reject();
        offloaded_data_t exp_d;
        logic [3:0] id;
        logic ap, rp;
        bit ok;
        instr_data_i  = mk(5'd7, 5'd0, 5'd0);
        instr_valid_i = 1'b1;
        exp_d = '{rs: instr_rs_i, instr_data: mk(5'd7, 5'd0, 5'd0),
                  id: 4'd2, mode: instr_mode_i};
        cyc();
        instr_valid_i = 1'b0;
        instr_data_i  = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (xif.issue_valid !== 1'b1 || xif.issue_data !== exp_d) begin
                n_err++;
                $display("FAIL issue_hold[%0d]: got v=%b %h want v=1 %h",
                         c, xif.issue_valid, xif.issue_data, exp_d);
            end
            cyc();
        end
        xif.issue_ready  = 1'b1;
        xif.issue_accept = 1'b0;
        #1;
        n_vec++;
        if ({instr_accept_o, instr_reject_o} !== 2'b01) begin
            n_err++;
            $display("FAIL reject_pulse: got %b want 01",
                     {instr_accept_o, instr_reject_o});
        end
        cyc();
        xif.issue_ready = 1'b0;
        issue_one(mk(5'd7, 5'd0, 5'd0), 1'b0, 1'b1, id, ap, rp, ok);
        n_vec++;
        if (!ok || id !== 4'd2 || ap !== 1'b1) begin
            n_err++;
            $display("FAIL id_after_reject: got ok=%b id=%0d acc=%b want 1 2 1",
                     ok, id, ap);
        end
    endtask

    task automatic test_full();
        logic [3:0] id;
        logic ap, rp;
        bit ok;
        logic [3:0] exp_ids [4] = '{4'd4, 4'd6, 4'd7, 4'd0};
        for (int i = 0; i < 4; i++) begin
            issue_one(mk(5'(10 + i), 5'd0, 5'd0), 1'b1, 1'b1, id, ap, rp, ok);
            n_vec++;
            if (!ok || id !== 4'(3 + i)) begin
                n_err++;
                $display("FAIL fill[%0d]: got ok=%b id=%0d want 1 %0d",
                         i, ok, id, 3 + i);
            end
        end
        instr_data_i  = mk(5'd20, 5'd0, 5'd0);
        instr_valid_i = 1'b1;
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_stall: got %b want 0", instr_ready_o);
        end
        set_result(1'b1, 4'd5, 5'd12, 1'b0, 32'd0);
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_same_cycle: got %b want 0", instr_ready_o);
        end
        cyc();
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_release: got %b want 1", instr_ready_o);
        end
        issue_one(mk(5'd20, 5'd0, 5'd0), 1'b1, 1'b1, id, ap, rp, ok);
        n_vec++;
        if (!ok || id !== 4'd7) begin
            n_err++;
            $display("FAIL refill: got ok=%b id=%0d want 1 7", ok, id);
        end
        instr_data_i  = mk(5'd21, 5'd0, 5'd0);
        instr_valid_i = 1'b1;
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_again: got %b want 0", instr_ready_o);
        end
        set_result(1'b1, 4'd3, 5'd10, 1'b0, 32'd0);
        cyc();
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        instr_data_i = mk(5'd21, 5'd20, 5'd0);
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reused_slot_hazard: got %b want 0", instr_ready_o);
        end
        instr_data_i = mk(5'd21, 5'd12, 5'd0);
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL freed_rd_clear: got %b want 1", instr_ready_o);
        end
        instr_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_result(1'b1, exp_ids[i], 5'd0, 1'b0, 32'd0);
            cyc();
        end
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        n_vec++;
        if ({busy_o, err_o} !== 2'b00) begin
            n_err++;
            $display("FAIL drained: got busy/err=%b want 00", {busy_o, err_o});
        end
    endtask

    task automatic test_wrap_err();
        logic [3:0] id;
        logic [3:0] exp_id;
        logic ap, rp;
        bit ok;
        exp_id = 4'd8;
        for (int i = 0; i < 17; i++) begin
            issue_one(mk(5'd1, 5'd2, 5'd3), 1'b0, 1'b1, id, ap, rp, ok);
            n_vec++;
            if (!ok || id !== exp_id || ap !== 1'b1) begin
                n_err++;
                $display("FAIL wrap[%0d]: got ok=%b id=%0d acc=%b want 1 %0d 1",
                         i, ok, id, ap, exp_id);
            end
            exp_id = exp_id + 4'd1;
        end
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_before: got %b want 0", err_o);
        end
        set_result(1'b1, 4'd9, 5'd7, 1'b1, 32'h1234_5678);
        #1;
        n_vec++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL orphan_write: got we=%b a=%0d d=%h want 1 7 12345678",
                     rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        cyc();
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %b want 1", err_o);
        end
        cyc();
        cyc();
        cyc();
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b want 1", err_o);
        end
        set_result(1'b1, 4'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        #1;
        n_vec++;
        if (rf_we_o !== 1'b0) begin
            n_err++;
            $display("FAIL x0_write: got %b want 0", rf_we_o);
        end
        cyc();
        set_result(1'b0, 4'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset_mid();
        logic [3:0] id;
        logic ap, rp;
        bit ok;
        issue_one(mk(5'd8, 5'd0, 5'd0), 1'b1, 1'b1, id, ap, rp, ok);
        n_vec++;
        if (!ok || id !== 4'd9 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_alloc: got ok=%b id=%0d busy=%b want 1 9 1",
                     ok, id, busy_o);
        end
        instr_data_i  = mk(5'd9, 5'd0, 5'd0);
        instr_valid_i = 1'b1;
        cyc();
        instr_valid_i = 1'b0;
        n_vec++;
        if (xif.issue_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_issue: got %b want 1", xif.issue_valid);
        end
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({xif.issue_valid, instr_accept_o, instr_reject_o, rf_we_o,
             busy_o, err_o} !== 6'b0 || xif.issue_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got %b data=%h want 000000 0",
                     {xif.issue_valid, instr_accept_o, instr_reject_o,
                      rf_we_o, busy_o, err_o}, xif.issue_data);
        end
        cyc();
        rst_ni = 1'b1;
        cyc();
        instr_data_i  = mk(5'd1, 5'd8, 5'd0);
        instr_valid_i = 1'b1;
        #1;
        n_vec++;
        if (instr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL table_cleared: got %b want 1", instr_ready_o);
        end
        issue_one(mk(5'd1, 5'd8, 5'd0), 1'b0, 1'b1, id, ap, rp, ok);
        n_vec++;
        if (!ok || id !== 4'd0) begin
            n_err++;
            $display("FAIL id_after_reset: got ok=%b id=%0d want 1 0", ok, id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_issue_wb();
        test_hazard();
        test_stall_reject();
        test_full();
        test_wrap_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
